// File: rtl/echo_timer_pkg.sv
// Shared definitions for the echo pulse-width timer: channel FSM states,
// synchroniser depth and the default timeout.
package echo_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_RISE = 2'd1,
    ST_MEASURE   = 2'd2
  } state_t;

  localparam int SYNC_STAGES        = 2;
  localparam int DEFAULT_TIMEOUT_US = 30000;

endpackage

// File: rtl/echo_channel.sv
// One echo channel: input synchroniser, edge detect, measurement FSM and counters.
// Optional ECHO_GLITCH_FILTER_EN requires two consecutive low cycles to end a pulse.
module echo_channel
  import echo_timer_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int TIMEOUT_US = DEFAULT_TIMEOUT_US
) (
  input  logic             clk_1mhz,
  input  logic             reset,
  input  logic             arm,
  input  logic             echo_in,
  output logic [WIDTH-1:0] meas_us,
  output logic             meas_valid,
  output logic             meas_timeout,
  output logic             busy
);

  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [WIDTH-1:0] TMO_LAST = WIDTH'(TIMEOUT_US - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   echo_s;
  logic                   echo_d;
  logic                   rise;
  logic                   tmo_hit;
  state_t                 state;
  logic [WIDTH-1:0]       tmo_cnt;
  logic [WIDTH-1:0]       width_cnt;
`ifdef ECHO_GLITCH_FILTER_EN
  logic                   low_seen;
`endif

  assign echo_s  = sync[SYNC_STAGES-1];
  assign rise    = echo_s & ~echo_d;
  assign tmo_hit = (tmo_cnt == TMO_LAST);

  function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] v,
                                               input logic [1:0]       step);
    logic [WIDTH:0] sum;
    sum = {1'b0, v} + {{(WIDTH-1){1'b0}}, step};
    return sum[WIDTH] ? CNT_MAX : sum[WIDTH-1:0];
  endfunction

  always_ff @(posedge clk_1mhz or posedge reset) begin
    if (reset) begin
      sync   <= '0;
      echo_d <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], echo_in};
      echo_d <= echo_s;
    end
  end

  // The timeout check sits ahead of every other transition so it wins over a
  // falling edge arriving in the same cycle.
  always_ff @(posedge clk_1mhz or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      tmo_cnt      <= '0;
      width_cnt    <= '0;
      meas_us      <= '0;
      meas_valid   <= 1'b0;
      meas_timeout <= 1'b0;
      busy         <= 1'b0;
`ifdef ECHO_GLITCH_FILTER_EN
      low_seen     <= 1'b0;
`endif
    end else begin
      meas_valid   <= 1'b0;
      meas_timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arm) begin
            state   <= ST_WAIT_RISE;
            tmo_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        ST_WAIT_RISE: begin
          if (tmo_hit) begin
            state        <= ST_IDLE;
            meas_timeout <= 1'b1;
            meas_us      <= CNT_MAX;
            busy         <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + WIDTH'(1);
            if (rise) begin
              state     <= ST_MEASURE;
              width_cnt <= WIDTH'(1);
`ifdef ECHO_GLITCH_FILTER_EN
              low_seen  <= 1'b0;
`endif
            end
          end
        end
        ST_MEASURE: begin
          if (tmo_hit) begin
            state        <= ST_IDLE;
            meas_timeout <= 1'b1;
            meas_us      <= CNT_MAX;
            busy         <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + WIDTH'(1);
`ifdef ECHO_GLITCH_FILTER_EN
            // A lone low cycle is a glitch: it is credited back as high time
            // once the echo returns, so the count skips ahead by two.
            if (echo_s) begin
              width_cnt <= sat_add(width_cnt, low_seen ? 2'd2 : 2'd1);
              low_seen  <= 1'b0;
            end else if (!low_seen) begin
              low_seen <= 1'b1;
            end else begin
              state      <= ST_IDLE;
              meas_us    <= width_cnt;
              meas_valid <= 1'b1;
              busy       <= 1'b0;
              low_seen   <= 1'b0;
            end
`else
            if (echo_s) begin
              width_cnt <= sat_add(width_cnt, 2'd1);
            end else begin
              state      <= ST_IDLE;
              meas_us    <= width_cnt;
              meas_valid <= 1'b1;
              busy       <= 1'b0;
            end
`endif
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/echo_pulse_timer.sv
// Multi-channel microsecond echo pulse-width timer; replicates echo_channel and
// packs the per-channel results. Honours ECHO_GLITCH_FILTER_EN via echo_channel.
module echo_pulse_timer
  import echo_timer_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int WIDTH      = 16,
  parameter int TIMEOUT_US = DEFAULT_TIMEOUT_US
) (
  input  logic                    clk_1mhz,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       arm,
  input  logic [NUM_CH-1:0]       echo_in,
  output logic [NUM_CH*WIDTH-1:0] meas_us,
  output logic [NUM_CH-1:0]       meas_valid,
  output logic [NUM_CH-1:0]       meas_timeout,
  output logic [NUM_CH-1:0]       busy
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    echo_channel #(
      .WIDTH      (WIDTH),
      .TIMEOUT_US (TIMEOUT_US)
    ) u_ch (
      .clk_1mhz     (clk_1mhz),
      .reset        (reset),
      .arm          (arm[i]),
      .echo_in      (echo_in[i]),
      .meas_us      (meas_us[i*WIDTH +: WIDTH]),
      .meas_valid   (meas_valid[i]),
      .meas_timeout (meas_timeout[i]),
      .busy         (busy[i])
    );
  end

endmodule

// File: doc/echo_pulse_timer.md
Name: echo_pulse_timer

Overview:
Multi-channel microsecond pulse-width timer for HC-SR04-style echo inputs, running on the 1 MHz timing clock. Each channel is armed by the trigger sequencer and waits for a rising echo edge. It then counts echo-high time in microseconds and reports one result with a valid or timeout strobe. Results feed the distance-conversion logic; a channel with no echo is reported as a timeout rather than hanging.

Parameters:
NUM_CH, 4, number of independent echo channels
WIDTH, 16, bit width of each per-channel result and counter
TIMEOUT_US, 30000, cycles (µs) after arm before a measurement is abandoned; must be < 2^WIDTH

Ports:
clk_1mhz  input  1  1 MHz timing clock
reset  input  1  asynchronous, active-high
arm  input  NUM_CH  per-channel 1-cycle start request; ignored while that channel is busy
echo_in  input  NUM_CH  raw asynchronous echo lines
meas_us  output  NUM_CH*WIDTH  per-channel result; channel i occupies bits [i*WIDTH +: WIDTH]
meas_valid  output  NUM_CH  1-cycle strobe: meas_us[i] is a good measurement
meas_timeout  output  NUM_CH  1-cycle strobe: channel i timed out
busy  output  NUM_CH  high from the cycle after arm is accepted until the cycle the strobe fires

Behaviour:
- Reset (async, active-high): all states IDLE, counters 0, synchronisers 0, meas_us 0, meas_valid 0, meas_timeout 0, busy 0. Reset asserted mid-measurement aborts it with no strobe.
- Input conditioning: echo_in is passed through a 2-FF synchroniser per channel, giving echo_s. A third register holds echo_d for edge detection. rise = echo_s & ~echo_d.
- Per-channel FSM with states IDLE, WAIT_RISE, MEASURE.
  - IDLE: arm[i]=1 → WAIT_RISE; tmo_cnt <= 0; busy <= 1.
  - WAIT_RISE: rise → MEASURE, width_cnt <= 1. An echo already high at arm time is not counted; a fresh rising edge is required.
  - MEASURE, echo_s=1: width_cnt increments and saturates at 2^WIDTH-1, with no wrap.
  - MEASURE, echo_s=0: meas_us[i] <= width_cnt; meas_valid[i] pulses 1 cycle; busy <= 0; → IDLE.
  - Result: echo_s high for N consecutive cycles yields meas_us = N.
- Timeout:
  - tmo_cnt increments every cycle in WAIT_RISE and MEASURE.
  - When tmo_cnt reaches TIMEOUT_US-1, the channel goes → IDLE, meas_timeout[i] pulses, meas_us[i] <= {WIDTH{1'b1}}, busy <= 0.
  - If timeout and a falling edge occur in the same cycle, the timeout wins.
- meas_us[i] holds its last value until that channel's next strobe.
- arm while busy is ignored with no side effect. This includes an arm in the same cycle as the strobe: the channel must return to IDLE first, so the earliest re-arm is the cycle after the strobe.
- Channels are fully independent. Simultaneous events on different channels are all serviced in the same cycle.
- Latency from the raw echo_in fall to the meas_valid strobe is 3 cycles: 2 synchroniser stages plus 1 FSM cycle.

Optional Feature:
Macro: ECHO_GLITCH_FILTER_EN.
- Defined: in MEASURE, the falling edge is accepted only after echo_s has been low for 2 consecutive cycles.
  - meas_us reports width_cnt as frozen at the first low cycle, so the 1-cycle filter delay is not counted.
  - A single-cycle low glitch is ignored. Its cycle is counted as high and width_cnt continues.
  - Valid strobe latency becomes 4 cycles.
- Undefined: the first low cycle ends the measurement, as described above.

Decomposition:
- Shared package/include echo_timer_pkg holds:
  - FSM state encodings ST_IDLE, ST_WAIT_RISE, ST_MEASURE (2-bit);
  - constant SYNC_STAGES=2;
  - default TIMEOUT_US value.
- Natural sub-module: echo_channel, one channel with its synchroniser, FSM and counters. It is generated NUM_CH times by the top, which only packs and unpacks the vectors.

Test Plan:
- Reset then arm ch0, echo high 580 cycles → meas_valid[0] single pulse, meas_us[0]=580, busy[0] drops the same cycle, other channels untouched.
- Arm ch1 with no echo → meas_timeout[1] exactly TIMEOUT_US cycles after arm (30000), meas_us[1]=16'hFFFF, meas_valid[1] never asserted.
- Echo high before arm on ch2, falls, then rises for 100 cycles → meas_us[2]=100; the pre-arm pulse is ignored.
- All 4 channels armed together, widths 10/200/3000/29000 → four independent valid strobes with matching values; ch3 either valids or times out depending on rise offset, and the bench checks it against a model.
- Second arm during MEASURE on ch0 and reset asserted mid-pulse on ch1 → ch0 result unaffected; ch1 returns to IDLE with all outputs 0 and no strobe.
- With ECHO_GLITCH_FILTER_EN: 50 high, 1 low, 49 high, then low → one strobe with meas_us=100. Without the macro: strobe with meas_us=50.
